vga_plot_arbiter: RTL and testbench
===================================

Name: vga_plot_arbiter

Overview:
- Shares the single VGA plot port (X, Y, color, drawOnVGA) between three pixel producers: 0 = map redraw FSM, 1 = character sprite drawer, 2 = overlay/UI drawer.
- Each producer requests the port, is granted exclusive ownership for a whole transaction, and plots pixels only while granted.
- Round-robin selection with a one-cycle handover gap. Sits between the draw engines and the VGA adapter.

Parameters:
- NREQ, 3, number of requesters; fixed at 3 for this revision; ptr/owner width 2.
- RESET_PTR, 2, initial last-served index, so requester 0 wins the first arbitration.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  3  per-requester ownership request; level, held for whole transaction.
- plot_in  in  3  per-requester pixel-write strobe.
- x_in  in  27  three 9-bit X coords; requester i at bits [9i+8:9i].
- y_in  in  24  three 8-bit Y coords; requester i at bits [8i+7:8i].
- color_in  in  9  three 3-bit colors; requester i at bits [3i+2:3i].
- grant  out  3  one-hot ownership, registered; all-zero when no owner.
- owner  out  2  index of current owner; valid only when busy=1.
- busy  out  1  high while any grant bit is high.
- X  out  9  registered plot X to VGA.
- Y  out  8  registered plot Y to VGA.
- color  out  3  registered plot color to VGA.
- drawOnVGA  out  1  registered plot strobe to VGA.
- plot_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset, sampled at posedge, overrides everything: state=IDLE, grant=0, owner=0, busy=0, X=0, Y=0, color=0, drawOnVGA=0, plot_err=0, last_ptr=RESET_PTR. Reset mid-transaction drops grant at that edge; no further pixels are emitted.
- States: IDLE, OWN, GAP.
- IDLE: at an edge with any req bit high, select winner k = first index with req high scanning (last_ptr+1) mod 3, (last_ptr+2) mod 3, last_ptr. Set grant=one-hot(k), owner=k, and go to OWN. Grant latency is 1 cycle from the req sample.
- OWN: at each edge, drawOnVGA <= grant[k] & req[k] & plot_in[k]. X, Y and color load from slice k only when that term is 1; otherwise they hold. Pixel latency is 1 cycle (plot_in at edge t appears on the outputs after edge t).
- OWN release: at an edge with req[k]=0, set grant=0, last_ptr=k, drawOnVGA=0, and go to GAP. A plot_in[k] sampled in the same cycle as req[k]=0 is dropped. Owners hold req through their last plot.
- GAP: exactly one cycle with no owner (busy=0). At the next edge, arbitrate exactly as in IDLE using the updated last_ptr. If no req is high, go to IDLE.
- Requests from non-owners during OWN are held pending; no preemption and no timeout.
- Back-to-back requests by the same requester:
  - If it is the only requester, it is re-granted after GAP.
  - Otherwise it goes last in round-robin order.
- plot_err is set at any edge where plot_in[i]=1 and grant[i]=0 for any i. It clears only on reset. The offending pixel is discarded.
- Slices are not range-checked; X up to 511 and Y up to 255 pass through unchanged. Range is the producer's responsibility.
- Output invariants: grant is always zero or one-hot; busy == |grant; drawOnVGA is never high while busy was low on the previous cycle.

Test Plan:
- Reset, then req=3'b001, requester 0 plots (x=5, y=7, color=3'b101) every cycle for 4 cycles, then drops req. Expect: grant=001 one cycle after req; 4 drawOnVGA pulses, each 1 cycle late, last with X=5, Y=7, color=101; grant=000 for 1 GAP cycle; return to IDLE.
- req=3'b111 held continuously, each owner releasing after 2 plots. Expect grant sequence 001, 010, 100, 001, with exactly one zero-grant cycle between owners.
- Requester 2 plots while requester 1 owns. Expect no drawOnVGA from requester 2's data and plot_err=1 staying high; a later reset clears it to 0.
- Owner 1 drops req in the same cycle it asserts plot_in (x=319, y=239). Expect no drawOnVGA pulse for that pixel and X/Y to retain the previous pixel's values.
- Assert reset while requester 0 owns mid-stream. Expect grant=000, drawOnVGA=0 and X=Y=color=0 on the next cycle. After reset releases with req=3'b011 held, requester 0 is granted first (last_ptr=2).
- Only requester 1 requests, releases, and re-requests 1 cycle later. Expect re-grant to 010 after exactly one GAP cycle.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the single VGA plot port between three pixel producers
// (0 = map redraw, 1 = character sprite, 2 = overlay/UI). Ownership is granted
// round-robin for a whole transaction, with a one-cycle gap between owners.
// The plot outputs are registered, so a pixel appears one cycle after its strobe.
module vga_plot_arbiter #(
  parameter int         NREQ      = 3,
  parameter logic [1:0] RESET_PTR = 2'd2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     plot_in,
  input  logic [9*NREQ-1:0]   x_in,
  input  logic [8*NREQ-1:0]   y_in,
  input  logic [3*NREQ-1:0]   color_in,
  output logic [NREQ-1:0]     grant,
  output logic [1:0]          owner,
  output logic                busy,
  output logic [8:0]          X,
  output logic [7:0]          Y,
  output logic [2:0]          color,
  output logic                drawOnVGA,
  output logic                plot_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] last_ptr;
  logic [2:0] pick;
  logic       sel_req;
  logic       sel_plot;
  logic [8:0] sel_x;
  logic [7:0] sel_y;
  logic [2:0] sel_c;

  // Round-robin choice: scan starting just after the last served index and
  // wrap around so the last owner has the lowest priority. Returns {found, idx}.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r,
                                         input logic [1:0]      last);
    logic [2:0] result;
    logic [1:0] cand;
    result = 3'b000;
    // Walk from lowest to highest priority so the best candidate is written last.
    for (int d = NREQ; d >= 1; d--) begin
      cand = 2'((int'(last) + d) % NREQ);
      if (r[cand]) result = {1'b1, cand};
    end
    return result;
  endfunction

  assign pick = rr_pick(req, last_ptr);

  // Route the current owner's request, strobe and pixel slice to the plot path.
  always_comb begin
    sel_req  = req[0];
    sel_plot = plot_in[0];
    sel_x    = x_in[8:0];
    sel_y    = y_in[7:0];
    sel_c    = color_in[2:0];
    case (owner)
      2'd1: begin
        sel_req  = req[1];
        sel_plot = plot_in[1];
        sel_x    = x_in[17:9];
        sel_y    = y_in[15:8];
        sel_c    = color_in[5:3];
      end
      2'd2: begin
        sel_req  = req[2];
        sel_plot = plot_in[2];
        sel_x    = x_in[26:18];
        sel_y    = y_in[23:16];
        sel_c    = color_in[8:6];
      end
      default: ;
    endcase
  end

  // Ownership FSM with registered grant/owner/busy, plot outputs and the sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= 2'd0;
      busy      <= 1'b0;
      X         <= 9'd0;
      Y         <= 8'd0;
      color     <= 3'd0;
      drawOnVGA <= 1'b0;
      plot_err  <= 1'b0;
      last_ptr  <= RESET_PTR;
    end else begin
      // A strobe from anyone without a grant is a protocol violation; its pixel is dropped.
      if (|(plot_in & ~grant)) plot_err <= 1'b1;
      drawOnVGA <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (pick[2]) begin
            grant <= NREQ'(1) << pick[1:0];
            owner <= pick[1:0];
            busy  <= 1'b1;
            state <= OWN;
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          if (!sel_req) begin
            // Release: a strobe coinciding with the dropped request is discarded.
            grant    <= '0;
            busy     <= 1'b0;
            last_ptr <= owner;
            state    <= GAP;
          end else if (sel_plot) begin
            drawOnVGA <= 1'b1;
            X         <= sel_x;
            Y         <= sel_y;
            color     <= sel_c;
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Testbench for vga_plot_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against a transaction-level reference model.
module tb_vga_plot_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  plot_in = '0;
  logic [26:0] x_in = '0;
  logic [23:0] y_in = '0;
  logic [8:0]  color_in = '0;
  logic [2:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic [8:0]  X;
  logic [7:0]  Y;
  logic [2:0]  color;
  logic        drawOnVGA;
  logic        plot_err;

  int errors = 0;
  int checks = 0;

  vga_plot_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .plot_in   (plot_in),
    .x_in      (x_in),
    .y_in      (y_in),
    .color_in  (color_in),
    .grant     (grant),
    .owner     (owner),
    .busy      (busy),
    .X         (X),
    .Y         (Y),
    .color     (color),
    .drawOnVGA (drawOnVGA),
    .plot_err  (plot_err)
  );

  always #5 clock = ~clock;

  // Reference model: who owns the port (-1 = nobody), who was served last,
  // and the last pixel that reached the VGA side.
  typedef struct packed {
    int         owner;
    int         last;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    logic       draw;
    logic       err;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(input mstate_t s, input logic rst,
                                         input logic [2:0] rq, input logic [2:0] pl,
                                         input logic [26:0] xi, input logic [23:0] yi,
                                         input logic [8:0] ci);
    mstate_t n;
    bit found;
    n = s;
    n.draw = 1'b0;
    if (rst) begin
      n.owner = -1; n.last = 2; n.x = '0; n.y = '0; n.c = '0; n.err = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) if (pl[i] && s.owner != i) n.err = 1'b1;
      if (s.owner >= 0) begin
        if (!rq[s.owner]) begin
          n.last  = s.owner;
          n.owner = -1;
        end else if (pl[s.owner]) begin
          n.draw = 1'b1;
          n.x = xi[9*s.owner +: 9];
          n.y = yi[8*s.owner +: 8];
          n.c = ci[3*s.owner +: 3];
        end
      end else begin
        found = 0;
        for (int d = 1; d <= 3; d++)
          if (!found && rq[(s.last + d) % 3]) begin
            found = 1;
            n.owner = (s.last + d) % 3;
          end
      end
    end
    return n;
  endfunction

  always @(posedge clock) m <= model_next(m, reset, req, plot_in, x_in, y_in, color_in);

  task automatic set_pix(input int i, input int xv, input int yv, input int cv);
    x_in[9*i +: 9]     = 9'(xv);
    y_in[8*i +: 8]     = 8'(yv);
    color_in[3*i +: 3] = 3'(cv);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 3'b111; plot_in = 3'b111;
    @(negedge clock); @(negedge clock);
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
    checks++; if ({X, Y, color} !== 20'd0) begin errors++; $display("FAIL reset_pixel: got X=%0d Y=%0d c=%0d want 0", X, Y, color); end
    checks++; if (drawOnVGA !== 1'b0 || plot_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got draw=%b err=%b want 0 0", drawOnVGA, plot_err); end
    reset = 1'b0; req = 3'b000; plot_in = 3'b000;
    @(negedge clock);
  endtask

  task automatic test_single_owner();
    int pulses;
    pulses = 0;
    req = 3'b001;
    @(negedge clock);
    checks++; if (grant !== 3'b001 || busy !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL single_grant: got g=%b busy=%b own=%0d want 001 1 0", grant, busy, owner); end
    set_pix(0, 5, 7, 5);
    plot_in = 3'b001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (drawOnVGA === 1'b1) pulses++;
      checks++; if (drawOnVGA !== 1'b1 || X !== 9'd5 || Y !== 8'd7 || color !== 3'b101) begin errors++; $display("FAIL single_pixel%0d: got d=%b X=%0d Y=%0d c=%b want 1 5 7 101", i, drawOnVGA, X, Y, color); end
    end
    req = 3'b000; plot_in = 3'b000;
    @(negedge clock);
    checks++; if (pulses != 4) begin errors++; $display("FAIL single_pulses: got %0d want 4", pulses); end
    checks++; if (grant !== 3'b000 || busy !== 1'b0 || drawOnVGA !== 1'b0) begin errors++; $display("FAIL single_gap: got g=%b busy=%b d=%b want 000 0 0", grant, busy, drawOnVGA); end
    @(negedge clock);
    checks++; if (grant !== 3'b000 || X !== 9'd5) begin errors++; $display("FAIL single_idle: got g=%b X=%0d want 000 5", grant, X); end
  endtask

  task automatic test_round_robin();
    int order[4] = '{0, 1, 2, 0};
    int k;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; req = 3'b111;
    @(negedge clock);
    for (int j = 0; j < 4; j++) begin
      k = order[j];
      checks++; if (grant !== 3'(1 << k) || owner !== 2'(k) || busy !== 1'b1) begin errors++; $display("FAIL rr_grant%0d: got g=%b own=%0d want %b %0d", j, grant, owner, 3'(1 << k), k); end
      set_pix(k, 10 + k, 20 + k, k + 1);
      plot_in = 3'(1 << k);
      @(negedge clock);
      checks++; if (drawOnVGA !== 1'b1 || X !== 9'(10 + k)) begin errors++; $display("FAIL rr_plot%0d: got d=%b X=%0d want 1 %0d", j, drawOnVGA, X, 10 + k); end
      @(negedge clock);
      req = 3'b111 & ~3'(1 << k); plot_in = 3'b000;
      @(negedge clock);
      checks++; if (grant !== 3'b000 || busy !== 1'b0 || drawOnVGA !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got g=%b busy=%b d=%b want 000 0 0", j, grant, busy, drawOnVGA); end
      req = 3'b111;
      @(negedge clock);
    end
    req = 3'b000;
    @(negedge clock); @(negedge clock);
  endtask

  task automatic test_plot_err();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; req = 3'b010;
    @(negedge clock);
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL err_grant: got %b want 010", grant); end
    set_pix(2, 77, 66, 4);
    plot_in = 3'b100;
    @(negedge clock);
    plot_in = 3'b000;
    checks++; if (plot_err !== 1'b1 || drawOnVGA !== 1'b0 || X !== 9'd0) begin errors++; $display("FAIL err_set: got err=%b d=%b X=%0d want 1 0 0", plot_err, drawOnVGA, X); end
    repeat (3) @(negedge clock);
    checks++; if (plot_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", plot_err); end
    req = 3'b000; reset = 1'b1;
    @(negedge clock);
    checks++; if (plot_err !== 1'b0 || grant !== 3'b000) begin errors++; $display("FAIL err_clear: got err=%b g=%b want 0 000", plot_err, grant); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_drop_same_cycle();
    req = 3'b010;
    @(negedge clock);
    set_pix(1, 100, 50, 3);
    plot_in = 3'b010;
    @(negedge clock);
    checks++; if (drawOnVGA !== 1'b1 || X !== 9'd100) begin errors++; $display("FAIL drop_prev: got d=%b X=%0d want 1 100", drawOnVGA, X); end
    set_pix(1, 319, 239, 6);
    req = 3'b000;
    @(negedge clock);
    plot_in = 3'b000;
    checks++; if (drawOnVGA !== 1'b0 || X !== 9'd100 || Y !== 8'd50 || color !== 3'd3) begin errors++; $display("FAIL drop_pixel: got d=%b X=%0d Y=%0d c=%0d want 0 100 50 3", drawOnVGA, X, Y, color); end
    checks++; if (grant !== 3'b000 || plot_err !== 1'b0) begin errors++; $display("FAIL drop_release: got g=%b err=%b want 000 0", grant, plot_err); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    req = 3'b001;
    @(negedge clock);
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL rmid_grant: got %b want 001", grant); end
    set_pix(0, 33, 44, 2);
    plot_in = 3'b001;
    @(negedge clock);
    checks++; if (drawOnVGA !== 1'b1 || X !== 9'd33) begin errors++; $display("FAIL rmid_plot: got d=%b X=%0d want 1 33", drawOnVGA, X); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (grant !== 3'b000 || busy !== 1'b0 || drawOnVGA !== 1'b0 || {X, Y, color} !== 20'd0) begin errors++; $display("FAIL rmid_reset: got g=%b busy=%b d=%b X=%0d Y=%0d c=%0d want all 0", grant, busy, drawOnVGA, X, Y, color); end
    reset = 1'b0; req = 3'b011; plot_in = 3'b000;
    @(negedge clock);
    checks++; if (grant !== 3'b001 || owner !== 2'd0) begin errors++; $display("FAIL rmid_regrant: got g=%b own=%0d want 001 0", grant, owner); end
    req = 3'b000;
    @(negedge clock); @(negedge clock);
  endtask

  task automatic test_rerequest();
    req = 3'b010;
    @(negedge clock);
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL rereq_first: got %b want 010", grant); end
    req = 3'b000;
    @(negedge clock);
    checks++; if (grant !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL rereq_gap: got g=%b busy=%b want 000 0", grant, busy); end
    req = 3'b010;
    @(negedge clock);
    checks++; if (grant !== 3'b010 || busy !== 1'b1) begin errors++; $display("FAIL rereq_again: got g=%b busy=%b want 010 1", grant, busy); end
    req = 3'b000;
    @(negedge clock); @(negedge clock);
  endtask

  task automatic test_random();
    logic [2:0] eg;
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      eg = (m.owner >= 0) ? 3'(1 << m.owner) : 3'b000;
      checks++; if (grant !== eg || busy !== (eg != 3'b000)) begin errors++; $display("FAIL rand_grant@%0d: got g=%b busy=%b want %b", n, grant, busy, eg); end
      if (m.owner >= 0) begin
        checks++; if (owner !== 2'(m.owner)) begin errors++; $display("FAIL rand_owner@%0d: got %0d want %0d", n, owner, m.owner); end
      end
      checks++; if (drawOnVGA !== m.draw || X !== m.x || Y !== m.y || color !== m.c) begin errors++; $display("FAIL rand_pixel@%0d: got d=%b X=%0d Y=%0d c=%0d want %b %0d %0d %0d", n, drawOnVGA, X, Y, color, m.draw, m.x, m.y, m.c); end
      checks++; if (plot_err !== m.err) begin errors++; $display("FAIL rand_err@%0d: got %b want %b", n, plot_err, m.err); end
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        if (req[i]) plot_in[i] = ($urandom_range(3) != 0);
        else        plot_in[i] = ($urandom_range(31) == 0);
      end
      x_in     = 27'($urandom);
      y_in     = 24'($urandom);
      color_in = 9'($urandom);
      reset    = ($urandom_range(199) == 0);
    end
    reset = 1'b0; req = 3'b000; plot_in = 3'b000;
    @(negedge clock);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    test_reset();
    test_single_owner();
    test_round_robin();
    test_plot_err();
    test_drop_same_cycle();
    test_reset_mid();
    test_rerequest();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
